// File: rtl/ps2_rx_fifo_if.sv
// PS/2 receiver bundle: board PS/2 pins on one side, CPU-facing scan-code pop port on the other.
// master = receiver core, slave = board/register-bridge side.
interface ps2_rx_fifo_if #(
    parameter int unsigned DEPTH = 16
);
    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

    logic             ps2_clk_in;
    logic             ps2_dat_in;
    logic             ps2_clk_oe;
    logic [7:0]       rd_data;
    logic             rd_valid;
    logic             rd_ready;
    logic [LVL_W-1:0] level;
    logic             frame_err;
    logic             overflow;
    logic             ovf_clr;

    modport master (
        input  ps2_clk_in, ps2_dat_in, rd_ready, ovf_clr,
        output ps2_clk_oe, rd_data, rd_valid, level, frame_err, overflow
    );

    modport slave (
        output ps2_clk_in, ps2_dat_in, rd_ready, ovf_clr,
        input  ps2_clk_oe, rd_data, rd_valid, level, frame_err, overflow
    );
endinterface

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: synchroniser, glitch filter, frame FSM with parity/stop/timeout
// checking, and a DEPTH-entry scan-code FIFO with optional clock inhibit while full.
module ps2_rx_fifo #(
    parameter int unsigned CLK_HZ          = 50_000_000,
    parameter int unsigned DEPTH           = 16,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned FILT_LEN        = 8,
    parameter int unsigned TIMEOUT_US      = 2000,
    parameter int unsigned INHIBIT_ON_FULL = 1
) (
    input  logic          clk_clk,
    input  logic          reset_reset_n,
    ps2_rx_fifo_if.master bus
);
    localparam int unsigned PTR_W       = $clog2(DEPTH);
    localparam int unsigned LVL_W       = PTR_W + 1;
    localparam int unsigned FCNT_W      = $clog2(FILT_LEN + 1);
    localparam int unsigned TIMEOUT_CYC = CLK_HZ / 1_000_000 * TIMEOUT_US;
    localparam int unsigned TO_W        = $clog2(TIMEOUT_CYC + 1);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } state_e;

    // Reset: asynchronous assert, synchronous release
    logic [1:0] rst_sync_q;
    logic       rst_n;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) rst_sync_q <= '0;
        else                rst_sync_q <= {rst_sync_q[0], 1'b1};
    end

    assign rst_n = rst_sync_q[1];

    // Input synchronisers, idle-high
    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] dat_sync_q;
    logic [1:0]             samp;

    always_ff @(posedge clk_clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync_q <= '1;
            dat_sync_q <= '1;
        end else begin
            clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], bus.ps2_clk_in};
            dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], bus.ps2_dat_in};
        end
    end

    assign samp = {dat_sync_q[SYNC_STAGES-1], clk_sync_q[SYNC_STAGES-1]};

    // Glitch filter: index 0 = clock, 1 = data; level flips after FILT_LEN differing samples
    logic [1:0]             filt_q, filt_d;
    logic [1:0][FCNT_W-1:0] fcnt_q, fcnt_d;
    logic                   clk_prev_q;

    always_comb begin
        filt_d = filt_q;
        fcnt_d = '0;
        for (int i = 0; i < 2; i++) begin
            if (samp[i] != filt_q[i]) begin
                if (fcnt_q[i] == FCNT_W'(FILT_LEN - 1)) filt_d[i] = samp[i];
                else                                     fcnt_d[i] = fcnt_q[i] + FCNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_q     <= 2'b11;
            fcnt_q     <= '0;
            clk_prev_q <= 1'b1;
        end else begin
            filt_q     <= filt_d;
            fcnt_q     <= fcnt_d;
            clk_prev_q <= filt_q[0];
        end
    end

    // Frame FSM and timeout
    state_e          state_q, state_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic            par_q, par_d;
    logic [TO_W-1:0] to_q, to_d;
    logic            frame_err_q, frame_err_d;
    logic            push_q, push_d;
    logic [7:0]      push_data_q, push_data_d;
    logic            oe_q, oe_d;
    logic            fall_c;
    logic            dat_c;
    logic            timeout_c;

    // Falls are masked while the clock is being inhibited
    assign fall_c    = clk_prev_q & ~filt_q[0] & ~oe_q;
    assign dat_c     = filt_q[1];
    assign timeout_c = (state_q != ST_IDLE) && !fall_c && (to_q == TO_W'(TIMEOUT_CYC - 1));

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        par_d       = par_q;
        to_d        = '0;
        frame_err_d = 1'b0;
        push_d      = 1'b0;
        push_data_d = push_data_q;

        if (state_q != ST_IDLE && !fall_c) to_d = to_q + TO_W'(1);

        case (state_q)
            ST_IDLE: begin
                if (fall_c && !dat_c) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = 3'd0;
                end
            end
            ST_DATA: begin
                if (fall_c) begin
                    shift_d   = {dat_c, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
                end
            end
            ST_PARITY: begin
                if (fall_c) begin
                    par_d   = dat_c;
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (fall_c) begin
                    if ((^{shift_q, par_q}) && dat_c) begin
                        push_d      = 1'b1;
                        push_data_d = shift_q;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (timeout_c) begin
            state_d     = ST_IDLE;
            frame_err_d = 1'b1;
        end
        if (oe_q) state_d = ST_IDLE;
    end

    always_ff @(posedge clk_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            to_q        <= '0;
            frame_err_q <= 1'b0;
            push_q      <= 1'b0;
            push_data_q <= '0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            to_q        <= to_d;
            frame_err_q <= frame_err_d;
            push_q      <= push_d;
            push_data_q <= push_data_d;
        end
    end

    // Scan-code FIFO with registered head
    logic [7:0]       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] count_q, count_d;
    logic             rd_valid_q, rd_valid_d;
    logic [7:0]       rd_data_q, rd_data_d;
    logic             overflow_q, overflow_d;
    logic             pop_c, full_c, wr_en_c, ovf_set_c;

    assign pop_c     = rd_valid_q & bus.rd_ready;
    assign full_c    = (count_q == FULL_LVL);
    assign wr_en_c   = push_q & (~full_c | pop_c);
    assign ovf_set_c = push_q & full_c & ~pop_c;

    always_comb begin
        wr_ptr_d   = wr_en_c ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d   = pop_c   ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d    = count_q;
        case ({wr_en_c, pop_c})
            2'b10:   count_d = count_q + LVL_W'(1);
            2'b01:   count_d = count_q - LVL_W'(1);
            default: count_d = count_q;
        endcase
        rd_valid_d = (count_d != '0);
        rd_data_d  = rd_data_q;
        // A byte written into the slot that becomes the head bypasses the memory
        if (rd_valid_d) begin
            if (wr_en_c && (wr_ptr_q == rd_ptr_d)) rd_data_d = push_data_q;
            else                                   rd_data_d = mem_q[rd_ptr_d];
        end
        overflow_d = ovf_set_c ? 1'b1 : (bus.ovf_clr ? 1'b0 : overflow_q);
        oe_d       = (INHIBIT_ON_FULL != 0) && full_c && (oe_q || state_q == ST_IDLE);
    end

    always_ff @(posedge clk_clk) begin
        if (wr_en_c) mem_q[wr_ptr_q] <= push_data_q;
    end

    always_ff @(posedge clk_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            overflow_q <= 1'b0;
            oe_q       <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            overflow_q <= overflow_d;
            oe_q       <= oe_d;
        end
    end

    assign bus.ps2_clk_oe = oe_q;
    assign bus.rd_data    = rd_data_q;
    assign bus.rd_valid   = rd_valid_q;
    assign bus.level      = count_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: two DEPTH=4 instances, one without and one with clock inhibit,
// driven by a PS/2 device model at 1 MHz system clock (40-cycle half-period = 40 us).
`timescale 1ns/1ps
module tb_ps2_rx_fifo;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ps2c = 1'b1;
    logic ps2d = 1'b1;
    logic sel = 1'b0;
    logic rdy_a = 1'b0, rdy_b = 1'b0;
    logic clr_a = 1'b0, clr_b = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   ferr_a = 0;
    int   ferr_b = 0;

    always #500 clk = ~clk;

    ps2_rx_fifo_if #(.DEPTH(4)) bus_a ();
    ps2_rx_fifo_if #(.DEPTH(4)) bus_b ();

    assign bus_a.ps2_clk_in = sel ? 1'b1 : ps2c;
    assign bus_a.ps2_dat_in = sel ? 1'b1 : ps2d;
    assign bus_b.ps2_clk_in = sel ? ps2c : 1'b1;
    assign bus_b.ps2_dat_in = sel ? ps2d : 1'b1;
    assign bus_a.rd_ready   = rdy_a;
    assign bus_b.rd_ready   = rdy_b;
    assign bus_a.ovf_clr    = clr_a;
    assign bus_b.ovf_clr    = clr_b;

    ps2_rx_fifo #(.CLK_HZ(1_000_000), .DEPTH(4), .SYNC_STAGES(2), .FILT_LEN(8),
                  .TIMEOUT_US(2000), .INHIBIT_ON_FULL(0))
        u_dut_a (.clk_clk(clk), .reset_reset_n(rst_n), .bus(bus_a.master));

    ps2_rx_fifo #(.CLK_HZ(1_000_000), .DEPTH(4), .SYNC_STAGES(2), .FILT_LEN(8),
                  .TIMEOUT_US(2000), .INHIBIT_ON_FULL(1))
        u_dut_b (.clk_clk(clk), .reset_reset_n(rst_n), .bus(bus_b.master));

    always @(negedge clk) begin
        if (bus_a.frame_err === 1'b1) ferr_a <= ferr_a + 1;
        if (bus_b.frame_err === 1'b1) ferr_b <= ferr_b + 1;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One PS/2 bit: data set mid-high, optional 3-cycle clock glitch, then 40 low / 20 high
    task automatic send_bit(input logic b, input logic glitch);
        ps2d = b;
        if (glitch) begin
            wait_cyc(10);
            ps2c = 1'b0;
            wait_cyc(3);
            ps2c = 1'b1;
            wait_cyc(7);
        end else begin
            wait_cyc(20);
        end
        ps2c = 1'b0;
        wait_cyc(40);
        ps2c = 1'b1;
        wait_cyc(20);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par_flip, input logic stop_bit,
                              input logic glitch);
        logic par;
        par = ~(^b) ^ par_flip;
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i], glitch && (i == 4));
        send_bit(par, 1'b0);
        send_bit(stop_bit, 1'b0);
        ps2d = 1'b1;
        wait_cyc(100);
    endtask

    task automatic pop_a();
        rdy_a = 1'b1;
        wait_cyc(1);
        rdy_a = 1'b0;
        wait_cyc(2);
    endtask

    task automatic pop_b();
        rdy_b = 1'b1;
        wait_cyc(1);
        rdy_b = 1'b0;
    endtask

    initial begin
        logic [7:0] byte_v;

        wait_cyc(5);
        rst_n = 1'b1;
        wait_cyc(5);

        // Reset state
        chk("rst_level",    32'(bus_a.level),      32'd0);
        chk("rst_valid",    32'(bus_a.rd_valid),   32'd0);
        chk("rst_data",     32'(bus_a.rd_data),    32'h00);
        chk("rst_ovf",      32'(bus_a.overflow),   32'd0);
        chk("rst_ferr",     32'(bus_a.frame_err),  32'd0);
        chk("rst_oe_b",     32'(bus_b.ps2_clk_oe), 32'd0);

        // Good frame
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
        chk("t1_data",  32'(bus_a.rd_data),  32'h1C);
        chk("t1_valid", 32'(bus_a.rd_valid), 32'd1);
        chk("t1_level", 32'(bus_a.level),    32'd1);
        chk("t1_ferr",  32'(ferr_a),         32'd0);
        pop_a();
        chk("t1_pop_level", 32'(bus_a.level),    32'd0);
        chk("t1_pop_valid", 32'(bus_a.rd_valid), 32'd0);

        // Parity error
        send_frame(8'h1C, 1'b1, 1'b1, 1'b0);
        chk("t2_level", 32'(bus_a.level), 32'd0);
        chk("t2_ferr",  32'(ferr_a),      32'd1);

        // Stop error
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
        chk("t3_level", 32'(bus_a.level), 32'd0);
        chk("t3_ferr",  32'(ferr_a),      32'd2);

        // Timeout after start + 3 data bits
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        ps2d = 1'b1;
        wait_cyc(2100);
        chk("t4_ferr",  32'(ferr_a),      32'd3);
        chk("t4_level", 32'(bus_a.level), 32'd0);
        send_frame(8'h29, 1'b0, 1'b1, 1'b0);
        chk("t4_next_data",  32'(bus_a.rd_data), 32'h29);
        chk("t4_next_level", 32'(bus_a.level),   32'd1);
        chk("t4_next_ferr",  32'(ferr_a),        32'd3);
        pop_a();

        // Overflow without inhibit
        for (int i = 1; i <= 5; i++) begin
            byte_v = 8'(i);
            send_frame(byte_v, 1'b0, 1'b1, 1'b0);
        end
        chk("t5_level", 32'(bus_a.level),    32'd4);
        chk("t5_ovf",   32'(bus_a.overflow), 32'd1);
        chk("t5_oe",    32'(bus_a.ps2_clk_oe), 32'd0);
        for (int i = 1; i <= 4; i++) begin
            chk("t5_pop_data", 32'(bus_a.rd_data), 32'(i));
            pop_a();
        end
        chk("t5_empty_level", 32'(bus_a.level),    32'd0);
        chk("t5_empty_valid", 32'(bus_a.rd_valid), 32'd0);
        chk("t5_ovf_sticky",  32'(bus_a.overflow), 32'd1);
        clr_a = 1'b1;
        wait_cyc(1);
        clr_a = 1'b0;
        wait_cyc(2);
        chk("t5_ovf_clr", 32'(bus_a.overflow), 32'd0);

        // Inhibit on full, with a clock glitch inside the third frame
        sel = 1'b1;
        for (int i = 0; i < 4; i++) begin
            byte_v = 8'h11 * 8'(i + 1);
            send_frame(byte_v, 1'b0, 1'b1, (i == 2));
            chk("t6_fill_level", 32'(bus_b.level), 32'(i + 1));
            if (i < 3) chk("t6_oe_not_full", 32'(bus_b.ps2_clk_oe), 32'd0);
        end
        chk("t6_oe_full", 32'(bus_b.ps2_clk_oe), 32'd1);
        chk("t6_ferr",    32'(ferr_b),           32'd0);
        send_frame(8'h55, 1'b0, 1'b1, 1'b0);
        chk("t6_inh_level", 32'(bus_b.level),    32'd4);
        chk("t6_inh_ovf",   32'(bus_b.overflow), 32'd0);
        chk("t6_inh_ferr",  32'(ferr_b),         32'd0);
        chk("t6_head",      32'(bus_b.rd_data),  32'h11);
        pop_b();
        wait_cyc(2);
        chk("t6_pop_level", 32'(bus_b.level),      32'd3);
        chk("t6_pop_oe",    32'(bus_b.ps2_clk_oe), 32'd0);
        chk("t6_pop_head",  32'(bus_b.rd_data),    32'h22);

        // Reset mid-frame flushes the FIFO without a frame error
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        rst_n = 1'b0;
        wait_cyc(3);
        rst_n = 1'b1;
        ps2d  = 1'b1;
        wait_cyc(10);
        chk("t6_rst_level", 32'(bus_b.level),    32'd0);
        chk("t6_rst_valid", 32'(bus_b.rd_valid), 32'd0);
        chk("t6_rst_ferr",  32'(ferr_b),         32'd0);
        send_frame(8'h66, 1'b0, 1'b1, 1'b0);
        chk("t6_after_data",  32'(bus_b.rd_data), 32'h66);
        chk("t6_after_level", 32'(bus_b.level),   32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
